hamming_dec_engine: RTL and testbench

Hardware SECDED (16,11) Hamming decoder engine attached to the data memory `dm1` next to the core in `top_level`. On a start pulse it reads 15 encoded 16-bit words from bytes 30–59, corrects any single-bit error, and flags double-bit errors. It writes each recovered 11-bit message plus a 2-bit status flag to bytes 0–29. It is the receive-side counterpart of the program-1 parity encoder and uses the same bit layout.

---
 rtl/hamming_pkg.sv | 32 +++
 rtl/hamming_secded_dec.sv | 34 +++
 rtl/hamming_dec_engine.sv | 149 ++++++++++++++
 tb/tb_hamming_dec_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types, flags, FSM states and defaults for the SECDED (16,11) decoder
package hamming_pkg;

  typedef logic [15:0] codeword_t;
  typedef logic [10:0] msg_t;

  typedef enum logic [1:0] {
    FLG_OK  = 2'b00,
    FLG_SEC = 2'b01,
    FLG_DED = 2'b10
  } dec_flag_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_DEC,
    S_WR_LO,
    S_WR_HI,
    S_FIN
  } dec_state_e;

  localparam int N_WORDS_DEF  = 15;
  localparam int IN_BASE_DEF  = 30;
  localparam int OUT_BASE_DEF = 0;

  // Data bits sit at Hamming positions 3,5,6,7,9..15; d1 is the LSB of the message.
  function automatic msg_t extract_msg(input codeword_t cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - combinational SECDED (16,11) codeword decoder
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  codeword_t cw,
  output msg_t      msg,
  output dec_flag_e flag
);

  logic [3:0] syn;
  logic       par;
  codeword_t  fixed;

  // Each syndrome bit is the parity of the positions whose index has that bit set.
  assign syn[0] = ^(cw & 16'hAAAA);
  assign syn[1] = ^(cw & 16'hCCCC);
  assign syn[2] = ^(cw & 16'hF0F0);
  assign syn[3] = ^(cw & 16'hFF00);
  assign par    = ^cw;

  always_comb begin
    fixed = cw;
    flag  = FLG_OK;
    if (par) begin
      // syn == 0 points at bit 0, i.e. the overall parity bit itself
      fixed[syn] = ~cw[syn];
      flag       = FLG_SEC;
    end else if (syn != 4'd0) begin
      flag = FLG_DED;
    end
    msg = extract_msg(fixed);
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// rtl/hamming_dec_engine.sv - memory-attached SECDED decoder engine; HAMMING_DEC_STATS_EN adds error counters
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int N_WORDS  = N_WORDS_DEF,
  parameter int IN_BASE  = IN_BASE_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF,
  parameter int AW       = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    mem_wr_data,
  output logic          mem_wr_en
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [3:0]    single_cnt,
  output logic [3:0]    double_cnt
`endif
);

  localparam logic [AW-1:0] IN_A  = AW'(IN_BASE);
  localparam logic [AW-1:0] OUT_A = AW'(OUT_BASE);
  localparam logic [3:0]    LAST  = 4'(N_WORDS - 1);

  dec_state_e state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] lo_q, hi_q;
  msg_t       msg_q;
  dec_flag_e  flag_q;

  logic          done_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    wdata_n;
  logic          wen_n;
  logic          accept;

  logic [AW-1:0] off_cur, off_nxt;
  msg_t          dec_msg;
  dec_flag_e     dec_flag;

  assign off_cur = AW'({idx, 1'b0});
  assign off_nxt = AW'({idx + 4'd1, 1'b0});

  hamming_secded_dec u_dec (
    .cw   ({hi_q, lo_q}),
    .msg  (dec_msg),
    .flag (dec_flag)
  );

  // Memory-side outputs are registered: each state's address/data is set on the edge entering it.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = Done;
    addr_n  = mem_addr;
    wdata_n = mem_wr_data;
    wen_n   = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          done_n  = 1'b0;
          idx_n   = 4'd0;
          addr_n  = IN_A;
          state_n = S_RD_LO;
        end
      end
      S_RD_LO: begin
        addr_n  = IN_A + off_cur + AW'(1);
        state_n = S_RD_HI;
      end
      S_RD_HI: begin
        state_n = S_DEC;
      end
      S_DEC: begin
        addr_n  = OUT_A + off_cur;
        wdata_n = dec_msg[7:0];
        wen_n   = 1'b1;
        state_n = S_WR_LO;
      end
      S_WR_LO: begin
        addr_n  = OUT_A + off_cur + AW'(1);
        wdata_n = {flag_q, 3'b000, msg_q[10:8]};
        wen_n   = 1'b1;
        state_n = S_WR_HI;
      end
      S_WR_HI: begin
        if (idx == LAST) begin
          state_n = S_FIN;
        end else begin
          idx_n   = idx + 4'd1;
          addr_n  = IN_A + off_nxt;
          state_n = S_RD_LO;
        end
      end
      S_FIN: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      idx         <= 4'd0;
      Done        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= 8'd0;
      mem_wr_en   <= 1'b0;
      lo_q        <= 8'd0;
      hi_q        <= 8'd0;
      msg_q       <= '0;
      flag_q      <= FLG_OK;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      Done        <= done_n;
      mem_addr    <= addr_n;
      mem_wr_data <= wdata_n;
      mem_wr_en   <= wen_n;
      if (state == S_RD_LO) lo_q <= mem_rd_data;
      if (state == S_RD_HI) hi_q <= mem_rd_data;
      if (state == S_DEC) begin
        msg_q  <= dec_msg;
        flag_q <= dec_flag;
      end
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset || accept) begin
      single_cnt <= 4'd0;
      double_cnt <= 4'd0;
    end else if (state == S_DEC) begin
      if (dec_flag == FLG_SEC) single_cnt <= single_cnt + 4'd1;
      if (dec_flag == FLG_DED) double_cnt <= double_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// tb/tb_hamming_dec_engine.sv - scoreboard bench for hamming_dec_engine with a behavioural memory and codec model
module tb_hamming_dec_engine;

  localparam int N    = 15;
  localparam int INB  = 30;
  localparam int OUTB = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done;
  logic [7:0] addr;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic       wen;
`ifdef HAMMING_DEC_STATS_EN
  logic [3:0] single_cnt;
  logic [3:0] double_cnt;
`endif

  hamming_dec_engine dut (
    .Clk         (clk),
    .Reset       (rst),
    .Start       (start),
    .Done        (done),
    .mem_addr    (addr),
    .mem_rd_data (rdata),
    .mem_wr_data (wdata),
    .mem_wr_en   (wen)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .single_cnt  (single_cnt),
    .double_cnt  (double_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0]  mem [256];
  logic [15:0] cw_a  [N];
  logic [15:0] exp_a [N];
  int          exp_s;
  int          exp_d;
  logic        load_req = 1'b0;
  wr_t         exp_q [$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  assign rdata = mem[addr];

  // Single owner of the memory array: preload on request, DUT writes otherwise.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        mem[INB + 2*i]      <= cw_a[i][7:0];
        mem[INB + 2*i + 1]  <= cw_a[i][15:8];
        mem[OUTB + 2*i]     <= 8'hA5;
        mem[OUTB + 2*i + 1] <= 8'hA5;
      end
    end
    if (wen) mem[addr] <= wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h expected no write", addr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {24'd0, addr}, {24'd0, mon_e.a});
        chk("wr_data", {24'd0, wdata}, {24'd0, mon_e.d});
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] c;
    logic [3:0]  s;
    c = '0;
    s = '0;
    for (int j = 0; j < 11; j++) c[dpos[j]] = m[j];
    for (int k = 1; k < 16; k++) if (c[k]) s = s ^ 4'(k);
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] m;
    for (int j = 0; j < 11; j++) m[j] = c[dpos[j]];
    return m;
  endfunction

  task automatic gen_random();
    logic [10:0] m;
    logic [15:0] c;
    int ne, b1, b2;
    exp_s = 0;
    exp_d = 0;
    for (int i = 0; i < N; i++) begin
      m  = 11'($urandom_range(0, 2047));
      c  = encode(m);
      ne = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (ne == 0) begin
        exp_a[i] = {5'b00000, m};
      end else if (ne == 1) begin
        c[b1] = ~c[b1];
        exp_a[i] = {5'b01000, m};
        exp_s++;
      end else begin
        c[b1] = ~c[b1];
        c[b2] = ~c[b2];
        exp_a[i] = {5'b10000, extract(c)};
        exp_d++;
      end
      cw_a[i] = c;
    end
  endtask

  task automatic do_run(input int rst_at, input int dup_at);
    int n;
    bit fin, was_rst;
    wr_t e;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.a = 8'(OUTB + 2*i);     e.d = exp_a[i][7:0];  exp_q.push_back(e);
      e.a = 8'(OUTB + 2*i + 1); e.d = exp_a[i][15:8]; exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_clear", {31'd0, done}, 32'd0);
    n = 0;
    fin = 1'b0;
    was_rst = 1'b0;
    while (!fin && n < 200) begin
      if (n == dup_at - 1) start = 1'b1;
      if (n == rst_at - 1) rst = 1'b1;
      @(posedge clk);
      n++;
      #1 start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        was_rst = 1'b1;
        fin = 1'b1;
        exp_q.delete();
      end else if (done) begin
        fin = 1'b1;
      end
    end
    if (was_rst) begin
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wen", {31'd0, wen}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
    end else begin
      chk("done_cycle", n, 76);
      chk("queue_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1 chk("done_hold", {31'd0, done}, 32'd1);
      for (int i = 0; i < N; i++)
        chk("mem_out", {16'd0, mem[OUTB + 2*i + 1], mem[OUTB + 2*i]}, {16'd0, exp_a[i]});
`ifdef HAMMING_DEC_STATS_EN
      chk("single_cnt", {28'd0, single_cnt}, exp_s);
      chk("double_cnt", {28'd0, double_cnt}, exp_d);
`endif
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_wen", {31'd0, wen}, 32'd0);
    chk("reset_addr", {24'd0, addr}, 32'd0);
    chk("reset_wdata", {24'd0, wdata}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < N; i++) begin
      cw_a[i]  = 16'hFFFF;
      exp_a[i] = 16'h07FF;
    end
    exp_s = 0;
    exp_d = 0;
    do_run(-1, -1);

    cw_a[0] = 16'h0000; exp_a[0] = 16'h0000;
    cw_a[1] = 16'hFFDF; exp_a[1] = 16'h47FF;
    cw_a[2] = 16'hFFFE; exp_a[2] = 16'h47FF;
    cw_a[3] = 16'hFFFC; exp_a[3] = 16'h87FF;
    cw_a[4] = 16'hFFF7; exp_a[4] = 16'h47FF;
    cw_a[5] = 16'hFFF3; exp_a[5] = 16'h87FE;
    exp_s = 3;
    exp_d = 2;
    do_run(-1, -1);

    gen_random();
    do_run(-1, 40);

    gen_random();
    do_run(20, -1);

    gen_random();
    do_run(-1, -1);

    gen_random();
    do_run(-1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
